// File: rtl/ic_hc_pkg.sv
// rtl/ic_hc_pkg.sv - shared types, JPEG marker bytes and width helper for the bitstream packer
package ic_hc_pkg;

  typedef enum logic [2:0] {
    ST_RUN  = 3'd0,
    ST_PAD  = 3'd1,
    ST_EOI1 = 3'd2,
    ST_EOI2 = 3'd3,
    ST_LAST = 3'd4
  } hc_state_e;

  localparam logic [7:0] JPEG_EOI_HI = 8'hFF;
  localparam logic [7:0] JPEG_EOI_LO = 8'hD9;
  localparam logic [7:0] STUFF_BYTE  = 8'h00;

  // Ceiling log2; clog2(1) is 0, callers pass N+1 when they need to hold the value N.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ic_hc_bitstream_packer_if.sv
// rtl/ic_hc_bitstream_packer_if.sv - codeword input and packed word output handshakes
interface ic_hc_bitstream_packer_if #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32
);
  localparam int LEN_W = $clog2(IN_W + 1);
  localparam int KW    = OUT_W / 8;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [LEN_W-1:0] in_len;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [KW-1:0]    out_keep;

  // Packer side: consumes codewords, produces packed words.
  modport slave (
    input  in_valid, in_data, in_len, out_ready,
    output in_ready, out_valid, out_data, out_keep
  );

  // Producer/consumer side around the packer.
  modport master (
    output in_valid, in_data, in_len, out_ready,
    input  in_ready, out_valid, out_data, out_keep
  );
endinterface

// File: rtl/ic_hc_byte_lane_assembler.sv
// rtl/ic_hc_byte_lane_assembler.sv - collects bytes into OUT_W-bit words, lane 0 first
module ic_hc_byte_lane_assembler
  import ic_hc_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  input  logic               last_req,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_data,
  output logic [OUT_W/8-1:0] out_keep,
  output logic               stall,
  output logic               final_accept
);
  localparam int NL = OUT_W / 8;
  localparam int LW = clog2(NL + 1);

  logic [LW-1:0]    lane_cnt;
  logic [LW-1:0]    wr_idx;
  logic [OUT_W-1:0] data_n;
  logic [NL-1:0]    part_keep;
  logic             accept;

  assign accept = out_valid & out_ready;
  assign stall  = out_valid & ~out_ready;

  // The final word is whatever is pending when LAST is reached; with nothing pending and
  // no filled lanes the image already ended on a word boundary that was taken earlier.
  assign final_accept = last_req & (out_valid ? out_ready : (lane_cnt == '0));

  // Next word image: a byte arriving on the accept cycle starts a fresh word in lane 0.
  always_comb begin
    wr_idx    = out_valid ? '0 : lane_cnt;
    data_n    = out_valid ? '0 : out_data;
    part_keep = '0;
    for (int i = 0; i < NL; i++) begin
      if (wr_idx == LW'(i)) begin
        data_n[i*8 +: 8] = byte_data;
      end
      part_keep[i] = (LW'(i) < lane_cnt);
    end
  end

  // Lane fill, word hand-off and the partial final word.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      lane_cnt  <= '0;
    end else if (byte_valid) begin
      out_data <= data_n;
      if (wr_idx == LW'(NL - 1)) begin
        out_valid <= 1'b1;
        out_keep  <= '1;
        lane_cnt  <= '0;
      end else begin
        out_valid <= 1'b0;
        lane_cnt  <= wr_idx + LW'(1);
      end
    end else if (accept) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (last_req && !out_valid && lane_cnt != '0) begin
      out_valid <= 1'b1;
      out_keep  <= part_keep;
      lane_cnt  <= '0;
    end
  end

endmodule

// File: rtl/ic_hc_bitstream_packer.sv
// rtl/ic_hc_bitstream_packer.sv - packs MSB-first codewords into byte-stuffed JPEG words
module ic_hc_bitstream_packer
  import ic_hc_pkg::*;
#(
  parameter int IN_W       = 64,
  parameter int OUT_W      = 32,
  parameter int BUF_W      = 128,
  parameter int APPEND_EOI = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  ic_hc_bitstream_packer_if.slave  bus,
  input  logic                     flush,
  output logic [31:0]              byte_count,
  output logic                     done
);
  localparam int LEN_W = clog2(IN_W + 1);
  localparam int CNT_W = clog2(BUF_W + 1);

  hc_state_e        state, state_n;
  logic [BUF_W-1:0] acc;
  logic [CNT_W-1:0] bit_cnt;
  logic             flush_pending;
  logic             stuff_pending;
  logic             rdy_en;
  logic [LEN_W-1:0] len_eff;
  logic [BUF_W-1:0] in_masked;
  logic             in_fire;
  logic             stall;
  logic             final_accept;
  logic             last_req;
  logic             byte_fire;
  logic             take_data;
  logic             take_pad;
  logic             set_stuff;
  logic             clr_stuff;
  logic [7:0]       byte_data;
  logic [7:0]       data_byte;
  logic [7:0]       pad_byte;

  assign len_eff   = (bus.in_len > LEN_W'(IN_W)) ? LEN_W'(IN_W) : bus.in_len;
  assign in_masked = BUF_W'(bus.in_data) & ((BUF_W'(1) << len_eff) - BUF_W'(1));

  // Room for a worst-case codeword is required, so an accept never overflows even if
  // no byte leaves the accumulator that cycle.
  assign bus.in_ready = rdy_en && (state == ST_RUN) && !flush_pending &&
                        (bit_cnt <= CNT_W'(BUF_W - IN_W));
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign last_req     = (state == ST_LAST);

  // Oldest 8 buffered bits; bits above bit_cnt are stale and never read.
  assign data_byte = 8'(acc >> (bit_cnt - CNT_W'(8)));
  // Remaining 1..7 bits, left-justified and padded with ones.
  assign pad_byte  = (acc[7:0] << (4'd8 - {1'b0, bit_cnt[2:0]})) | (8'hFF >> bit_cnt[2:0]);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_n;
    end
  end

  // Next-state: drain, pad, marker bytes, final word, back to RUN.
  always_comb begin
    state_n = state;
    case (state)
      ST_RUN:  if (flush_pending && bit_cnt < CNT_W'(8) && !stuff_pending) state_n = ST_PAD;
      ST_PAD:  if (bit_cnt == '0 && !stuff_pending)
                 state_n = (APPEND_EOI != 0) ? ST_EOI1 : ST_LAST;
      ST_EOI1: if (!stall) state_n = ST_EOI2;
      ST_EOI2: if (!stall) state_n = ST_LAST;
      ST_LAST: if (final_accept) state_n = ST_RUN;
      default: state_n = ST_RUN;
    endcase
  end

  // Byte extractor: one byte per cycle, a pending stuff byte always goes first.
  always_comb begin
    byte_fire = 1'b0;
    byte_data = STUFF_BYTE;
    take_data = 1'b0;
    take_pad  = 1'b0;
    set_stuff = 1'b0;
    clr_stuff = 1'b0;
    if (!stall) begin
      case (state)
        ST_RUN, ST_PAD: begin
          if (stuff_pending) begin
            byte_fire = 1'b1;
            clr_stuff = 1'b1;
          end else if (bit_cnt >= CNT_W'(8)) begin
            byte_fire = 1'b1;
            byte_data = data_byte;
            take_data = 1'b1;
            set_stuff = (data_byte == 8'hFF);
          end else if (state == ST_PAD && bit_cnt != '0) begin
            byte_fire = 1'b1;
            byte_data = pad_byte;
            take_pad  = 1'b1;
            set_stuff = (pad_byte == 8'hFF);
          end
        end
        ST_EOI1: begin
          byte_fire = 1'b1;
          byte_data = JPEG_EOI_HI;
        end
        ST_EOI2: begin
          byte_fire = 1'b1;
          byte_data = JPEG_EOI_LO;
        end
        default: ;
      endcase
    end
  end

  // Accumulator, bit count, flush/stuff flags, byte counter and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc           <= '0;
      bit_cnt       <= '0;
      flush_pending <= 1'b0;
      stuff_pending <= 1'b0;
      rdy_en        <= 1'b0;
      byte_count    <= '0;
      done          <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      done   <= final_accept;
      if (in_fire) begin
        acc <= (acc << len_eff) | in_masked;
      end
      if (take_pad) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + (in_fire ? CNT_W'(len_eff) : '0) - (take_data ? CNT_W'(8) : '0);
      end
      if (set_stuff) begin
        stuff_pending <= 1'b1;
      end else if (clr_stuff) begin
        stuff_pending <= 1'b0;
      end
      if (last_req && final_accept) begin
        flush_pending <= 1'b0;
      end else if (state == ST_RUN && flush) begin
        flush_pending <= 1'b1;
      end
      byte_count <= byte_count + {31'd0, byte_fire};
    end
  end

  // Oversized codeword lengths are clipped in hardware but should never be presented.
  a_len_in_range: assert property (@(posedge clk) disable iff (reset)
    (bus.in_valid && bus.in_ready) |-> (bus.in_len <= LEN_W'(IN_W)));

  ic_hc_byte_lane_assembler #(
    .OUT_W(OUT_W)
  ) u_lane_asm (
    .clk          (clk),
    .reset        (reset),
    .byte_valid   (byte_fire),
    .byte_data    (byte_data),
    .last_req     (last_req),
    .out_ready    (bus.out_ready),
    .out_valid    (bus.out_valid),
    .out_data     (bus.out_data),
    .out_keep     (bus.out_keep),
    .stall        (stall),
    .final_accept (final_accept)
  );

endmodule

// File: tb/tb_ic_hc_bitstream_packer.sv
// tb/tb_ic_hc_bitstream_packer.sv - directed vector bench for the bitstream packer
module tb_ic_hc_bitstream_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] byte_count;
  logic        done;

  always #5 clk = ~clk;

  ic_hc_bitstream_packer_if #(.IN_W(64), .OUT_W(32)) ifc ();

  ic_hc_bitstream_packer #(
    .IN_W(64), .OUT_W(32), .BUF_W(128), .APPEND_EOI(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (ifc),
    .flush      (flush),
    .byte_count (byte_count),
    .done       (done)
  );

  typedef struct {
    logic [63:0] d0, d1, d2;
    int          l0, l1, l2;
    int          n;
    bit          fl;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    int          exp_bc;
    int          exp_done;
    int          exp_words;
  } vec_t;

  vec_t        vecs[7];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          w0, g0, dn0;
  logic [31:0] word_q[$];
  logic [3:0]  keep_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  bit          mbits[$];

  // Output monitor: accepted words, their kept bytes, and done pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (ifc.out_valid && ifc.out_ready) begin
        word_q.push_back(ifc.out_data);
        keep_q.push_back(ifc.out_keep);
        for (int k = 0; k < 4; k++) begin
          if (ifc.out_keep[k]) got_q.push_back(ifc.out_data[k*8 +: 8]);
        end
      end
      if (done) done_cnt = done_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mark();
    w0  = word_q.size();
    g0  = got_q.size();
    dn0 = done_cnt;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mark();
  endtask

  task automatic send(input logic [63:0] d, input int l, input bit fl);
    int n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    ifc.in_len   = 7'(l);
    @(negedge clk);
    while (!ifc.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("accept_%0h", d), {63'd0, ifc.in_ready}, 64'd1);
    flush = fl;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cnt == dn0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", {63'd0, done_cnt != dn0}, 64'd1);
  endtask

  task automatic wait_words(input int cnt, input int limit);
    int n = 0;
    while (word_q.size() - w0 < cnt && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  function automatic logic [63:0] bp_data(input int i);
    if (i == 3) return 64'hFF00_FF12_3456_789A;
    return 64'h0123_4567_89AB_CDEF + 64'(i) * 64'h0101_0101_0101_0101;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    vecs[0] = '{64'hA5, 64'h3C, 64'h1234, 8, 8, 16, 3, 0, 32'h34123CA5, 4'hF, 4, 0, 1};
    vecs[1] = '{64'hFF, 64'h11, 64'h22, 8, 8, 8, 3, 0, 32'h221100FF, 4'hF, 4, 0, 1};
    vecs[2] = '{64'h5, 64'h0, 64'h0, 3, 0, 0, 1, 1, 32'h00D9FFBF, 4'h7, 3, 1, 1};
    vecs[3] = '{64'h7F, 64'h0, 64'h0, 7, 0, 0, 1, 1, 32'hD9FF00FF, 4'hF, 4, 1, 1};
    vecs[4] = '{64'hFFFF, 64'hDEADBEEFC3, 64'h0, 0, 8, 0, 2, 1, 32'h00D9FFC3, 4'h7, 3, 1, 1};
    vecs[5] = '{64'hABC, 64'h0, 64'h0, 12, 0, 0, 1, 1, 32'hD9FFCFAB, 4'hF, 4, 1, 1};
    vecs[6] = '{64'hFFFF, 64'h0, 64'h0, 16, 0, 0, 1, 1, 32'h00FF00FF, 4'hF, 6, 1, 2};

    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_len    = '0;
    ifc.out_ready = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, ifc.out_data}, 64'd0);
    chk("rst_out_keep", {60'd0, ifc.out_keep}, 64'd0);
    chk("rst_byte_count", {32'd0, byte_count}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_in_ready", {63'd0, ifc.in_ready}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mark();
    @(negedge clk);
    chk("in_ready_first_cycle", {63'd0, ifc.in_ready}, 64'd0);
    @(negedge clk);
    chk("in_ready_second_cycle", {63'd0, ifc.in_ready}, 64'd1);
    @(posedge clk); #1;

    // Table-driven vectors.
    for (int v = 0; v < 7; v++) begin
      reset_dut();
      if (vecs[v].n >= 1) send(vecs[v].d0, vecs[v].l0, vecs[v].fl && vecs[v].n == 1);
      if (vecs[v].n >= 2) send(vecs[v].d1, vecs[v].l1, vecs[v].fl && vecs[v].n == 2);
      if (vecs[v].n >= 3) send(vecs[v].d2, vecs[v].l2, vecs[v].fl && vecs[v].n == 3);
      if (vecs[v].fl) wait_done(300);
      else wait_words(1, 300);
      repeat (6) @(posedge clk);
      #1;
      chk($sformatf("v%0d_words", v), 64'(word_q.size() - w0), 64'(vecs[v].exp_words));
      chk($sformatf("v%0d_data", v), {32'd0, (word_q.size() > w0) ? word_q[w0] : 32'hxxxxxxxx},
          {32'd0, vecs[v].exp_data});
      chk($sformatf("v%0d_keep", v), {60'd0, (keep_q.size() > w0) ? keep_q[w0] : 4'hx},
          {60'd0, vecs[v].exp_keep});
      chk($sformatf("v%0d_byte_count", v), {32'd0, byte_count}, 64'(vecs[v].exp_bc));
      chk($sformatf("v%0d_done_pulses", v), 64'(done_cnt - dn0), 64'(vecs[v].exp_done));
    end

    // Backpressure: 40 cycles of out_ready low under continuous 64-bit beats.
    reset_dut();
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      for (int bi = 63; bi >= 0; bi--) mbits.push_back(bp_data(i)[bi]);
    end
    exp_q.delete();
    while (mbits.size() >= 8) begin
      b = 8'h00;
      for (int k = 0; k < 8; k++) b = {b[6:0], mbits.pop_front()};
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
    fork
      begin
        for (int i = 0; i < 10; i++) send(bp_data(i), 64, 1'b0);
      end
      begin
        repeat (40) @(negedge clk);
        chk("bp_in_ready_low", {63'd0, ifc.in_ready}, 64'd0);
        chk("bp_out_valid_held", {63'd0, ifc.out_valid}, 64'd1);
        chk("bp_nothing_taken", 64'(word_q.size() - w0), 64'd0);
        @(posedge clk); #1;
        ifc.out_ready = 1'b1;
      end
    join
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_done(1000);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_stream_len", 64'(got_q.size() - g0), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("bp_byte_%0d", i),
          {56'd0, (g0 + i < got_q.size()) ? got_q[g0 + i] : 8'hxx}, {56'd0, exp_q[i]});
    end
    chk("bp_byte_count", {32'd0, byte_count}, 64'(exp_q.size()));

    // Reset with two lanes filled, then a clean image.
    reset_dut();
    send(64'hA5, 8, 1'b0);
    send(64'h3C, 8, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_pre_reset_count", {32'd0, byte_count}, 64'd2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("mid_rst_byte_count", {32'd0, byte_count}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mark();
    send(64'hA5, 8, 1'b1);
    wait_done(300);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_words", 64'(word_q.size() - w0), 64'd1);
    chk("mid_data", {32'd0, (word_q.size() > w0) ? word_q[w0] : 32'hxxxxxxxx}, 64'h00D9FFA5);
    chk("mid_keep", {60'd0, (keep_q.size() > w0) ? keep_q[w0] : 4'hx}, 64'h7);
    chk("mid_byte_count", {32'd0, byte_count}, 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
